// File: rtl/pow_pkg.sv
// Shared types and defaults for the pow_engine exponentiation unit.
package pow_pkg;

    localparam int STATE_W = 2;
    localparam int XW_DEF  = 4;
    localparam int AW_DEF  = 4;
    localparam int PW_DEF  = 30;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } pow_state_e;

endpackage

// File: rtl/pow_engine_if.sv
// Operand/strobe/result bundle for pow_engine; master drives strobes, slave is the engine.
interface pow_engine_if
    import pow_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int AW = AW_DEF,
    parameter int PW = PW_DEF
);
    logic          i_load;
    logic          i_start;
    logic          i_clear;
    logic          i_ack;
    logic [XW-1:0] i_X;
    logic [AW-1:0] i_A;
    logic          o_busy;
    logic          o_done;
    logic [PW-1:0] o_P;
    logic          o_ovf;

    modport master (
        output i_load, i_start, i_clear, i_ack, i_X, i_A,
        input  o_busy, o_done, o_P, o_ovf
    );

    modport slave (
        input  i_load, i_start, i_clear, i_ack, i_X, i_A,
        output o_busy, o_done, o_P, o_ovf
    );
endinterface

// File: rtl/pow_mul.sv
// PW x PW unsigned multiplier keeping the low PW bits; POW_OVF_EN adds an upper-half-nonzero flag.
module pow_mul
    import pow_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic [PW-1:0] a_i,
    input  logic [PW-1:0] b_i,
    output logic [PW-1:0] p_o
`ifdef POW_OVF_EN
    ,
    output logic          hi_nz_o
`endif
);

`ifdef POW_OVF_EN
    localparam int FW = 2 * PW;
    logic [FW-1:0] full;

    assign full    = FW'(a_i) * FW'(b_i);
    assign p_o     = full[PW-1:0];
    assign hi_nz_o = |full[FW-1:PW];
`else
    assign p_o = a_i * b_i;
`endif

endmodule

// File: rtl/pow_engine.sv
// Square-and-multiply engine computing P = X^A; latency follows the bit-length of A.
// Define POW_OVF_EN to enable overflow detection with saturation of o_P.
module pow_engine
    import pow_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int AW = AW_DEF,
    parameter int PW = PW_DEF
) (
    input logic         i_clk,
    input logic         i_rst,
    pow_engine_if.slave pw_if
);

    localparam logic [STATE_W-1:0] ST_IDLE   = IDLE;
    localparam logic [STATE_W-1:0] ST_LOADED = LOADED;
    localparam logic [STATE_W-1:0] ST_CALC   = CALC;
    localparam logic [STATE_W-1:0] ST_DONE   = DONE;

    logic [STATE_W-1:0] state_q, state_d;
    logic [XW-1:0]      x_q, x_d;
    logic [AW-1:0]      a_q, a_d;
    logic [AW-1:0]      e_q, e_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      base_q, base_d;
    logic [PW-1:0]      p_q, p_d;
    logic [PW-1:0]      acc_prod, base_prod;

`ifdef POW_OVF_EN
    logic acc_hi, base_hi;
    logic base_ovf_q, base_ovf_d;
    logic acc_ovf_q, acc_ovf_d;
    logic ovf_q, ovf_d;
`endif

    pow_mul #(.PW(PW)) u_mul_acc (
        .a_i     (acc_q),
        .b_i     (base_q),
        .p_o     (acc_prod)
`ifdef POW_OVF_EN
        ,
        .hi_nz_o (acc_hi)
`endif
    );

    pow_mul #(.PW(PW)) u_mul_base (
        .a_i     (base_q),
        .b_i     (base_q),
        .p_o     (base_prod)
`ifdef POW_OVF_EN
        ,
        .hi_nz_o (base_hi)
`endif
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        e_d     = e_q;
        acc_d   = acc_q;
        base_d  = base_q;
        p_d     = p_q;
`ifdef POW_OVF_EN
        base_ovf_d = base_ovf_q;
        acc_ovf_d  = acc_ovf_q;
        ovf_d      = ovf_q;
`endif
        if (pw_if.i_clear) begin
            state_d = ST_IDLE;
            x_d     = '0;
            a_d     = '0;
            e_d     = '0;
            acc_d   = '0;
            base_d  = '0;
            p_d     = '0;
`ifdef POW_OVF_EN
            base_ovf_d = 1'b0;
            acc_ovf_d  = 1'b0;
            ovf_d      = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pw_if.i_load) begin
                        x_d     = pw_if.i_X;
                        a_d     = pw_if.i_A;
                        state_d = ST_LOADED;
                    end
                end
                ST_LOADED, ST_DONE: begin
                    // In DONE a reload outranks a restart; LOADED ignores i_load entirely.
                    if (state_q == ST_DONE && pw_if.i_load) begin
                        x_d     = pw_if.i_X;
                        a_d     = pw_if.i_A;
                        state_d = ST_LOADED;
                    end else if (pw_if.i_start) begin
                        acc_d   = PW'(1);
                        base_d  = PW'(x_q);
                        e_d     = a_q;
                        state_d = ST_CALC;
`ifdef POW_OVF_EN
                        base_ovf_d = 1'b0;
                        acc_ovf_d  = 1'b0;
                        ovf_d      = 1'b0;
`endif
                    end else if (state_q == ST_DONE && pw_if.i_ack) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (e_q != '0) begin
                        if (e_q[0]) begin
                            acc_d = acc_prod;
`ifdef POW_OVF_EN
                            if (acc_hi || base_ovf_q)
                                acc_ovf_d = 1'b1;
`endif
                        end
                        if ((e_q >> 1) != '0) begin
                            base_d = base_prod;
`ifdef POW_OVF_EN
                            if (base_hi)
                                base_ovf_d = 1'b1;
`endif
                        end
                        e_d = e_q >> 1;
                    end else begin
`ifdef POW_OVF_EN
                        p_d   = acc_ovf_q ? '1 : acc_q;
                        ovf_d = acc_ovf_q;
`else
                        p_d = acc_q;
`endif
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            a_q     <= '0;
            e_q     <= '0;
            acc_q   <= '0;
            base_q  <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            e_q     <= e_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            p_q     <= p_d;
        end
    end

`ifdef POW_OVF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            base_ovf_q <= 1'b0;
            acc_ovf_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            base_ovf_q <= base_ovf_d;
            acc_ovf_q  <= acc_ovf_d;
            ovf_q      <= ovf_d;
        end
    end

    assign pw_if.o_ovf = ovf_q;
`else
    assign pw_if.o_ovf = 1'b0;
`endif

    assign pw_if.o_busy = (state_q == ST_CALC);
    assign pw_if.o_done = (state_q == ST_DONE);
    assign pw_if.o_P    = p_q;

endmodule

// File: tb/tb_pow_engine.sv
// Directed bench for pow_engine: vector table on the default build plus a PW=16 instance.
module tb_pow_engine;
    import pow_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pow_engine_if #(.XW(4), .AW(4), .PW(30)) b   ();
    pow_engine_if #(.XW(4), .AW(4), .PW(16)) b16 ();

    pow_engine #(.XW(4), .AW(4), .PW(30)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .pw_if (b)
    );

    pow_engine #(.XW(4), .AW(4), .PW(16)) u_dut16 (
        .i_clk (clk),
        .i_rst (rst),
        .pw_if (b16)
    );

    typedef struct {
        logic [3:0]  x;
        logic [3:0]  a;
        logic [29:0] p;
        bit          ovf;
        int          lat;
    } vec_t;

    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input bit sel16, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(sel16 ? b16.o_done : b.o_done) && lat < 40);
    endtask

    task automatic load(input logic [3:0] x, input logic [3:0] a);
        b.i_X    = x;
        b.i_A    = a;
        b.i_load = 1'b1;
        tick();
        b.i_load = 1'b0;
    endtask

    task automatic start();
        b.i_start = 1'b1;
        tick();
        b.i_start = 1'b0;
    endtask

    task automatic ack();
        b.i_ack = 1'b1;
        tick();
        b.i_ack = 1'b0;
    endtask

    function automatic logic [29:0] exp30(input logic [29:0] p, input bit ovf);
`ifdef POW_OVF_EN
        return ovf ? 30'h3FFF_FFFF : p;
`else
        return p;
`endif
    endfunction

    function automatic bit expovf(input bit ovf);
`ifdef POW_OVF_EN
        return ovf;
`else
        return 1'b0 & ovf;
`endif
    endfunction

    initial begin
        int  lat;
        bit  seen;

        vecs[0] = '{x: 4'd3,  a: 4'd4,  p: 30'd81,        ovf: 1'b0, lat: 4};
        vecs[1] = '{x: 4'd5,  a: 4'd0,  p: 30'd1,         ovf: 1'b0, lat: 1};
        vecs[2] = '{x: 4'd0,  a: 4'd0,  p: 30'd1,         ovf: 1'b0, lat: 1};
        vecs[3] = '{x: 4'd0,  a: 4'd7,  p: 30'd0,         ovf: 1'b0, lat: 4};
        vecs[4] = '{x: 4'd1,  a: 4'd15, p: 30'd1,         ovf: 1'b0, lat: 5};
        vecs[5] = '{x: 4'd2,  a: 4'd10, p: 30'd1024,      ovf: 1'b0, lat: 5};
        vecs[6] = '{x: 4'd15, a: 4'd7,  p: 30'd170859375, ovf: 1'b0, lat: 4};
        vecs[7] = '{x: 4'd7,  a: 4'd8,  p: 30'd5764801,   ovf: 1'b0, lat: 5};
        vecs[8] = '{x: 4'd8,  a: 4'd10, p: 30'd0,         ovf: 1'b1, lat: 5};
        vecs[9] = '{x: 4'd15, a: 4'd8,  p: 30'd415406977, ovf: 1'b1, lat: 5};

        b.i_load = 0; b.i_start = 0; b.i_clear = 0; b.i_ack = 0; b.i_X = '0; b.i_A = '0;
        b16.i_load = 0; b16.i_start = 0; b16.i_clear = 0; b16.i_ack = 0; b16.i_X = '0; b16.i_A = '0;

        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_busy", 64'(b.o_busy), 64'd0);
        chk("rst_done", 64'(b.o_done), 64'd0);
        chk("rst_P",    64'(b.o_P),    64'd0);
        chk("rst_ovf",  64'(b.o_ovf),  64'd0);

        // i_start in IDLE must not launch anything
        start();
        chk("idle_start_busy", 64'(b.o_busy), 64'd0);
        tick();
        chk("idle_start_done", 64'(b.o_done), 64'd0);

        for (int i = 0; i < 10; i++) begin
            load(vecs[i].x, vecs[i].a);
            start();
            chk($sformatf("v%0d_busy", i), 64'(b.o_busy), 64'd1);
            wait_done(1'b0, lat);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_P", i), 64'(b.o_P), 64'(exp30(vecs[i].p, vecs[i].ovf)));
            chk($sformatf("v%0d_ovf", i), 64'(b.o_ovf), 64'(expovf(vecs[i].ovf)));
            chk($sformatf("v%0d_busy_end", i), 64'(b.o_busy), 64'd0);
            ack();
            chk($sformatf("v%0d_ack_done", i), 64'(b.o_done), 64'd0);
        end

        // Restart from DONE, reload from DONE, then acknowledge
        load(4'd3, 4'd4);
        start();
        wait_done(1'b0, lat);
        start();
        chk("re_busy", 64'(b.o_busy), 64'd1);
        chk("re_done_low", 64'(b.o_done), 64'd0);
        wait_done(1'b0, lat);
        chk("re_lat", 64'(lat), 64'd4);
        chk("re_P", 64'(b.o_P), 64'd81);
        load(4'd2, 4'd10);
        chk("reload_done_low", 64'(b.o_done), 64'd0);
        start();
        wait_done(1'b0, lat);
        chk("reload_lat", 64'(lat), 64'd5);
        chk("reload_P", 64'(b.o_P), 64'd1024);
        ack();
        chk("ack_done", 64'(b.o_done), 64'd0);
        chk("ack_busy", 64'(b.o_busy), 64'd0);
        chk("ack_P_kept", 64'(b.o_P), 64'd1024);

        // i_load during CALC is ignored
        load(4'd3, 4'd4);
        start();
        b.i_X = 4'd2; b.i_A = 4'd10; b.i_load = 1'b1;
        tick();
        tick();
        b.i_load = 1'b0;
        lat = 2;
        while (!b.o_done && lat < 40) begin
            tick();
            lat++;
        end
        chk("calc_load_lat", 64'(lat), 64'd4);
        chk("calc_load_P", 64'(b.o_P), 64'd81);
        ack();

        // i_clear two cycles into a long calculation
        load(4'd2, 4'd15);
        start();
        tick();
        b.i_clear = 1'b1;
        tick();
        b.i_clear = 1'b0;
        chk("clr_busy", 64'(b.o_busy), 64'd0);
        chk("clr_done", 64'(b.o_done), 64'd0);
        chk("clr_P", 64'(b.o_P), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= b.o_done | b.o_busy;
        end
        chk("clr_quiet", 64'(seen), 64'd0);

        // Same abort through i_rst, after leaving a nonzero held result
        load(4'd3, 4'd4);
        start();
        wait_done(1'b0, lat);
        ack();
        load(4'd2, 4'd15);
        start();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 64'(b.o_busy), 64'd0);
        chk("rst_mid_done", 64'(b.o_done), 64'd0);
        chk("rst_mid_P", 64'(b.o_P), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= b.o_done | b.o_busy;
        end
        chk("rst_mid_quiet", 64'(seen), 64'd0);

        // PW=16: 15^5 = 759375 overflows 16 bits
        b16.i_X = 4'd15; b16.i_A = 4'd5; b16.i_load = 1'b1;
        tick();
        b16.i_load = 1'b0;
        b16.i_start = 1'b1;
        tick();
        b16.i_start = 1'b0;
        wait_done(1'b1, lat);
        chk("p16_lat", 64'(lat), 64'd4);
`ifdef POW_OVF_EN
        chk("p16_P", 64'(b16.o_P), 64'hFFFF);
        chk("p16_ovf", 64'(b16.o_ovf), 64'd1);
`else
        chk("p16_P", 64'(b16.o_P), 64'd38479);
        chk("p16_ovf", 64'(b16.o_ovf), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
